// File: rtl/mux_nin_pipe.sv
// mux_nin_pipe: registered N-input selector with valid/ready on both sides.
// Output register plus a one-entry skid register. in_ready is simply "skid
// empty", so it is a flop and never sees out_ready combinationally.
module mux_nin_pipe #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic                  sysclk,
  input  logic                  cpu_resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      mux_s,
  input  logic [N_IN*WIDTH-1:0] mux_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      mux_out,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  sel_err,
  input  logic                  err_clr
);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } item_t;

  logic [N_IN-1:0][WIDTH-1:0] in_arr;
  assign in_arr = mux_in;

  item_t new_item;
  logic  in_range;
  logic  acc, drain;

  item_t out_q, out_d, skid_q, skid_d;
  logic  out_vld_q, out_vld_d;
  logic  skid_vld_q, skid_vld_d;
  logic  err_q, err_d;

  assign acc   = in_valid && !skid_vld_q;
  assign drain = out_vld_q && out_ready;

  // Decode the select; an out-of-range select yields zero data.
  always_comb begin
    new_item.sel  = mux_s;
    new_item.data = '0;
    in_range      = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (mux_s == SEL_W'(k)) begin
        new_item.data = in_arr[k];
        in_range      = 1'b1;
      end
    end
  end

  // Storage next state: the output slot refills from skid first, then from
  // the input; the skid only fills when the output slot is held.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!out_vld_q || drain) begin
      out_vld_d = skid_vld_q || acc;
      if (skid_vld_q) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end else if (acc) begin
        out_d = new_item;
      end
    end else if (acc) begin
      skid_d     = new_item;
      skid_vld_d = 1'b1;
    end
  end

  // Sticky error: a bad accept beats a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (acc && !in_range) err_d = 1'b1;
    else if (err_clr)     err_d = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge sysclk) begin
    if (!cpu_resetn) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = !skid_vld_q;
  assign out_valid = out_vld_q;
  assign mux_out   = out_q.data;
  assign out_sel   = out_q.sel;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_nin_pipe.sv
// Bench for mux_nin_pipe: two instances (32b x 5 inputs, 8b x 16 inputs)
// share handshake stimulus and are checked every cycle against a queue model.
module tb_mux_nin_pipe;

  logic         sysclk = 1'b0;
  logic         rstn;
  logic         in_valid, out_ready, err_clr;
  logic [3:0]   s;
  logic [159:0] bus;

  logic        a_in_ready, a_out_valid, a_sel_err;
  logic [31:0] a_mux_out;
  logic [2:0]  a_out_sel;
  logic        b_in_ready, b_out_valid, b_sel_err;
  logic [7:0]  b_mux_out;
  logic [3:0]  b_out_sel;

  always #5 sysclk = ~sysclk;

  mux_nin_pipe #(.WIDTH(32), .N_IN(5), .SEL_W(3)) dut_a (
    .sysclk(sysclk), .cpu_resetn(rstn), .in_valid(in_valid), .in_ready(a_in_ready),
    .mux_s(s[2:0]), .mux_in(bus), .out_valid(a_out_valid), .out_ready(out_ready),
    .mux_out(a_mux_out), .out_sel(a_out_sel), .sel_err(a_sel_err), .err_clr(err_clr));

  mux_nin_pipe #(.WIDTH(8), .N_IN(16), .SEL_W(4)) dut_b (
    .sysclk(sysclk), .cpu_resetn(rstn), .in_valid(in_valid), .in_ready(b_in_ready),
    .mux_s(s), .mux_in(bus[127:0]), .out_valid(b_out_valid), .out_ready(out_ready),
    .mux_out(b_mux_out), .out_sel(b_out_sel), .sel_err(b_sel_err), .err_clr(err_clr));

  int n_cmp = 0, n_bad = 0, n_acc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Selected value of input s from a flat bus of n inputs of w bits.
  function automatic logic [31:0] pick(input int n, input int w, input int sel, input logic [159:0] b);
    logic [159:0] m;
    if (sel >= n) return 32'd0;
    m = (160'd1 << w) - 160'd1;
    return 32'((b >> (sel * w)) & m);
  endfunction

  function automatic logic [159:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: a FIFO of accepted raw inputs, at most two deep.
  typedef struct { logic [3:0] s; logic [159:0] bus; } raw_t;
  raw_t q[$];
  raw_t last;
  bit   err_a, err_b, m_acc, m_drn;

  always @(posedge sysclk) begin
    if (!rstn) begin
      q.delete();
      last  = '{4'd0, 160'd0};
      err_a = 1'b0;
      err_b = 1'b0;
    end else begin
      m_acc = in_valid && (q.size() < 2);
      m_drn = (q.size() > 0) && out_ready;
      if (m_acc && (s[2:0] >= 3'd5)) err_a = 1'b1;
      else if (err_clr)              err_a = 1'b0;
      if (err_clr) err_b = 1'b0;   // every 4-bit select is in range for 16 inputs
      if (m_drn) void'(q.pop_front());
      if (m_acc) begin
        q.push_back('{s, bus});
        n_acc++;
      end
      if (q.size() > 0) last = q[0];
    end
  end

  // Compare both DUTs against the model every cycle.
  always @(negedge sysclk) begin
    if (chk_en) begin
      chk("a_out_valid", 32'(a_out_valid), 32'(q.size() > 0));
      chk("a_in_ready",  32'(a_in_ready),  32'(q.size() < 2));
      chk("a_mux_out",   a_mux_out, pick(5, 32, int'(last.s[2:0]), last.bus));
      chk("a_out_sel",   32'(a_out_sel), 32'(last.s[2:0]));
      chk("a_sel_err",   32'(a_sel_err), 32'(err_a));
      chk("b_out_valid", 32'(b_out_valid), 32'(q.size() > 0));
      chk("b_in_ready",  32'(b_in_ready),  32'(q.size() < 2));
      chk("b_mux_out",   32'(b_mux_out), pick(16, 8, int'(last.s), last.bus));
      chk("b_out_sel",   32'(b_out_sel), 32'(last.s));
      chk("b_sel_err",   32'(b_sel_err), 32'(err_b));
    end
  end

  task automatic tick();
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  initial begin
    int target, cyc;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    s = 4'd0; bus = '0;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd1);
    chk("rst_mux_out",   a_mux_out,        32'd0);
    chk("rst_sel_err",   32'(a_sel_err),   32'd0);

    // First item with one-cycle latency, then streaming.
    rstn = 1'b1; in_valid = 1'b1; out_ready = 1'b1; s = 4'd2;
    bus = rnd(); bus[95:64] = 32'hDEADBEEF;
    tick();
    chk("lat_valid", 32'(a_out_valid), 32'd1);
    chk("lat_data",  a_mux_out,        32'hDEADBEEF);
    chk("lat_sel",   32'(a_out_sel),   32'd2);
    for (int i = 0; i < 6; i++) begin
      s = 4'(i % 5); bus = rnd();
      tick();
      chk("stream_ready", 32'(a_in_ready), 32'd1);
    end
    in_valid = 1'b0; tick();

    // Backpressure fills the skid; release drains in order.
    out_ready = 1'b0; in_valid = 1'b1;
    s = 4'd0; bus = '0; bus[31:0] = 32'h11; tick();
    s = 4'd1; bus = '0; bus[63:32] = 32'h22; tick();
    chk("bp_in_ready", 32'(a_in_ready), 32'd0);
    chk("bp_hold",     a_mux_out,       32'h11);
    in_valid = 1'b0; tick();
    chk("bp_still",    a_mux_out,       32'h11);
    out_ready = 1'b1; tick();
    chk("bp_second",   a_mux_out,       32'h22);
    chk("bp_ready",    32'(a_in_ready), 32'd1);
    tick();
    chk("bp_empty",    32'(a_out_valid), 32'd0);

    // Out-of-range select: zero data, sticky error, clear, set-wins.
    in_valid = 1'b1; s = 4'd6; bus = rnd(); tick();
    chk("bad_data", a_mux_out,       32'd0);
    chk("bad_sel",  32'(a_out_sel),  32'd6);
    chk("bad_err",  32'(a_sel_err),  32'd1);
    in_valid = 1'b0; tick();
    chk("err_sticky", 32'(a_sel_err), 32'd1);
    err_clr = 1'b1; tick();
    chk("err_clr", 32'(a_sel_err), 32'd0);
    in_valid = 1'b1; s = 4'd6; tick();
    chk("err_set_wins", 32'(a_sel_err), 32'd1);
    in_valid = 1'b0; tick();
    err_clr = 1'b0;
    chk("err_clr2", 32'(a_sel_err), 32'd0);

    // Stalled bad select is not accepted and does not set the error.
    out_ready = 1'b0; in_valid = 1'b1;
    s = 4'd1; bus = rnd(); tick();
    s = 4'd3; bus = rnd(); tick();
    s = 4'd7; tick(); tick();
    chk("stall_err", 32'(a_sel_err), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1; tick(); tick();
    chk("stall_empty", 32'(a_out_valid), 32'd0);

    // Reset while two items are held.
    out_ready = 1'b0; in_valid = 1'b1;
    s = 4'd6; bus = rnd(); tick();
    s = 4'd4; bus = rnd(); tick();
    in_valid = 1'b0; rstn = 1'b0; tick();
    chk("r2_valid", 32'(a_out_valid), 32'd0);
    chk("r2_ready", 32'(a_in_ready),  32'd1);
    chk("r2_data",  a_mux_out,        32'd0);
    chk("r2_err",   32'(a_sel_err),   32'd0);
    rstn = 1'b1; in_valid = 1'b1; s = 4'd3; bus = '0; bus[127:96] = 32'hCAFE0003; tick();
    in_valid = 1'b0; out_ready = 1'b1;
    chk("r2_first", a_mux_out, 32'hCAFE0003);
    tick();
    chk("r2_alone", 32'(a_out_valid), 32'd0);

    // Random valid/ready traffic, 1000 accepted items.
    target = n_acc + 1000;
    cyc = 0;
    while (n_acc < target && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      s         = 4'($urandom);
      bus       = rnd();
      err_clr   = ($urandom_range(0, 15) == 0);
      tick();
      cyc++;
    end
    chk("rand_budget", 32'(n_acc >= target), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    tick(); tick(); tick();
    chk("rand_drained", 32'(a_out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_nin_pipe.md
Name: mux_nin_pipe

Overview:
- Parametrised, registered N-input selector with a valid/ready handshake on both sides.
- It is the pipelined successor of the datapath 4-input muxes, for paths that must be cut by a register, such as writeback source select and forwarding select into a registered ALU operand.
- Output stage is a 2-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`.
- An out-of-range select yields zero data and raises a sticky error flag.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N_IN, 4, number of data inputs; legal range 2..16.
- SEL_W, 2, select width; must be at least clog2(N_IN).

Ports:
- sysclk  in  1  clock; all state updates on the rising edge.
- cpu_resetn  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream presents a valid select/data set.
- in_ready  out  1  block can accept a transfer this cycle.
- mux_s  in  SEL_W  select, sampled on an input transfer.
- mux_in  in  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  mux_out/out_sel hold a valid result.
- out_ready  in  1  downstream accepts the result.
- mux_out  out  WIDTH  selected data, registered.
- out_sel  out  SEL_W  select value that produced mux_out.
- sel_err  out  1  sticky: an out-of-range select was accepted.
- err_clr  in  1  clears sel_err.

Behaviour:
- Reset (sysclk edge with cpu_resetn=0):
  - out_valid=0, mux_out=0, out_sel=0, sel_err=0, in_ready=1, skid entry empty.
  - Reset overrides any transfer in that cycle and discards in-flight data.
- Transfer rules:
  - Input transfer when in_valid and in_ready are both 1.
  - Output transfer when out_valid and out_ready are both 1.
- Selection, evaluated at input transfer:
  - If mux_s < N_IN, data = input mux_s.
  - Otherwise data = 0 and sel_err is set.
- Latency: an accepted item appears on mux_out/out_valid in the next cycle when the output register is empty or being drained.
- Storage is an output register plus one skid register:
  - Empty: out_valid=0, in_ready=1. Accept -> One.
  - One: out_valid=1, in_ready=1.
    - Accept with drain -> One, output loads the new item.
    - Accept without drain -> Two, new item goes to skid.
    - Drain only -> Empty.
  - Two: out_valid=1, in_ready=0.
    - Drain -> One, skid moves to output.
    - in_valid is ignored.
- in_ready is a registered output: 1 exactly when the skid register is empty.
- Ordering is strictly FIFO: no item is dropped or duplicated.
- mux_out/out_sel are stable while out_valid=1 and out_ready=0.
- When out_valid=0, mux_out and out_sel hold their last values.
- sel_err:
  - Set on an accepted out-of-range select.
  - Cleared by err_clr=1.
  - If set and clear happen in the same cycle, set wins.
  - Only accepted items can set it; an out-of-range mux_s presented while in_ready=0 does not.
- mux_s and mux_in are don't-care when in_valid=0.

Test Plan:
- Reset, then in_valid=1, mux_s=2, input 2 = 0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, mux_out=0xDEADBEEF, out_sel=2; continuous streaming at one item per cycle.
- out_ready=0, send items A=0x11 (sel 0) and B=0x22 (sel 1) -> in_ready drops to 0 after B; mux_out holds 0x11. Raise out_ready -> 0x11 then 0x22 over two consecutive cycles; in_ready returns to 1.
- N_IN=5, SEL_W=3, mux_s=6 accepted -> mux_out=0, out_sel=6, sel_err=1 and stays 1. Pulse err_clr -> 0. Repeat with err_clr=1 in the same cycle as the bad accept -> sel_err=1.
- Stall (in_ready=0) with mux_s=7 presented -> sel_err stays 0 and no item is enqueued.
- Assert cpu_resetn=0 while in state Two -> after that edge out_valid=0, in_ready=1, mux_out=0, sel_err=0; the first item after reset emerges alone.
- Randomised valid/ready toggling, 1000 items, WIDTH=8, N_IN=16 -> scoreboard matches order and values exactly.
